hex_scroll_ctrl: RTL and testbench

Scrolling-message controller for the six 7-segment displays HEX5..HEX0. Holds a writable message buffer of up to 16 glyph codes, divides CLOCK_50 into a step tick, and moves the message one digit per tick from HEX5 toward HEX0 with wrap-around. It replaces hard-coded per-position display cases and is the single owner of all six HEX outputs.

---
 rtl/hex_disp_pkg.sv | 21 ++
 rtl/hex_glyph_dec.sv | 32 +++
 rtl/hex_scroll_ctrl.sv | 158 +++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants and types for the scrolling HEX display controller.
package hex_disp_pkg;

  localparam int DIGITS    = 6;
  localparam int BUF_DEPTH = 16;

  // Glyph codes; 0x0-0x9 are the decimal digits themselves.
  localparam logic [3:0] GLYPH_H     = 4'hA;
  localparam logic [3:0] GLYPH_I     = 4'hB;
  localparam logic [3:0] GLYPH_L     = 4'hC;
  localparam logic [3:0] GLYPH_E     = 4'hD;
  localparam logic [3:0] GLYPH_DASH  = 4'hE;
  localparam logic [3:0] GLYPH_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/hex_glyph_dec.sv
// Glyph code to active-low 7-segment pattern; bit 0 is segment a, bit 6 is g.
module hex_glyph_dec
  import hex_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [0:6] seg
);

  // Pure lookup; literals are written in a..g order.
  always_comb begin
    seg = 7'b1111111;
    case (code)
      4'h0:        seg = 7'b0000001;
      4'h1:        seg = 7'b1001111;
      4'h2:        seg = 7'b0010010;
      4'h3:        seg = 7'b0000110;
      4'h4:        seg = 7'b1001100;
      4'h5:        seg = 7'b0100100;
      4'h6:        seg = 7'b0100000;
      4'h7:        seg = 7'b0001111;
      4'h8:        seg = 7'b0000000;
      4'h9:        seg = 7'b0000100;
      GLYPH_H:     seg = 7'b1001000;
      GLYPH_I:     seg = 7'b1111001;
      GLYPH_L:     seg = 7'b1110001;
      GLYPH_E:     seg = 7'b0110000;
      GLYPH_DASH:  seg = 7'b1111110;
      default:     seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolling message controller driving HEX5..HEX0 from a 16-entry glyph buffer.
// Optional HEX_SCROLL_DIR_EN adds a 'dir' input selecting scroll direction.
module hex_scroll_ctrl
  import hex_disp_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 1
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [4:0] len,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
`ifdef HEX_SCROLL_DIR_EN
  input  logic       dir,
`endif
  output logic       busy,
  output logic       wrap,
  output logic [0:6] HEX0,
  output logic [0:6] HEX1,
  output logic [0:6] HEX2,
  output logic [0:6] HEX3,
  output logic [0:6] HEX4,
  output logic [0:6] HEX5
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  state_t                          state_q, state_d;
  logic [PW-1:0]                   pre_q, pre_d;
  logic [4:0]                      off_q, off_d;
  logic [4:0]                      lr_q, lr_d;
  logic                            wrap_d;
  logic [BUF_DEPTH-1:0][3:0]       buf_q;
  logic [4:0]                      per;
  logic                            dir_w;
  logic [DIGITS-1:0][3:0]          code_w;
  logic [DIGITS-1:0][0:6]          seg_w, seg_q;

`ifdef HEX_SCROLL_DIR_EN
  assign dir_w = dir;
`else
  assign dir_w = 1'b0;
`endif

  // Short messages are padded with blanks to a 6-digit period.
  assign per = (lr_q > 5'd6) ? lr_q : 5'd6;

  // State, prescaler, offset and latched length registers.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pre_q   <= '0;
      off_q   <= '0;
      lr_q    <= '0;
      wrap    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      off_q   <= off_d;
      lr_q    <= lr_d;
      wrap    <= wrap_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Next-state logic; stop wins, then pause, then the step counter.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    off_d   = off_q;
    lr_d    = lr_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        pre_d = '0;
        off_d = '0;
        if (start && !stop && (len != 5'd0)) begin
          state_d = RUN;
          lr_d    = (len > 5'd16) ? 5'd16 : len;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          pre_d   = '0;
          off_d   = '0;
        end else if (pause) begin
          state_d = HOLD;
        end else if (pre_q == PW'(DIV - 1)) begin
          pre_d = '0;
          if (dir_w) begin
            if (off_q == 5'd0) begin
              off_d  = per - 5'd1;
              wrap_d = 1'b1;
            end else begin
              off_d = off_q - 5'd1;
            end
          end else if (off_q == per - 5'd1) begin
            off_d  = '0;
            wrap_d = 1'b1;
          end else begin
            off_d = off_q + 5'd1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          pre_d   = '0;
          off_d   = '0;
        end else if (pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Message buffer; writable in every state.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) buf_q <= {BUF_DEPTH{GLYPH_BLANK}};
    else if (wr_en) buf_q[wr_addr] <= wr_data;
  end

  // Per-digit strip index (5-k-off) mod P; both operands are below P so one
  // conditional add of P is enough to fold a negative difference.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    localparam logic [4:0] T = 5'(DIGITS - 1 - k);
    logic [4:0] idx;
    assign idx = (T >= off_q) ? (T - off_q) : (T + per - off_q);
    assign code_w[k] = (state_q == IDLE) ? GLYPH_BLANK :
                       (idx < lr_q)      ? buf_q[idx[3:0]] : GLYPH_BLANK;
    hex_glyph_dec u_dec (.code(code_w[k]), .seg(seg_w[k]));
  end

  // Registered segment outputs, blank out of reset.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) seg_q <= {DIGITS{7'b1111111}};
    else     seg_q <= seg_w;
  end

  assign HEX0 = seg_q[0];
  assign HEX1 = seg_q[1];
  assign HEX2 = seg_q[2];
  assign HEX3 = seg_q[3];
  assign HEX4 = seg_q[4];
  assign HEX5 = seg_q[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Randomized + directed bench for hex_scroll_ctrl with a behavioural model.
module tb_hex_scroll_ctrl;
  localparam int DIV = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RST = 1'b0;
  logic       wr_en = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, dir = 1'b0;
  logic [3:0] wr_addr = '0, wr_data = '0;
  logic [4:0] len = '0;
  logic       busy, wrap;
  logic [0:6] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int total = 0;
  int bad   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  hex_scroll_ctrl #(.CLK_HZ(4), .STEP_HZ(1)) dut (
    .CLOCK_50(CLOCK_50), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .len(len), .start(start), .stop(stop), .pause(pause),
`ifdef HEX_SCROLL_DIR_EN
    .dir(dir),
`endif
    .busy(busy), .wrap(wrap),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  // Segment patterns a..g, active-low.
  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_H     = 7'b1001000;
  localparam logic [6:0] S_I     = 7'b1111001;
  logic [6:0] seg_tab [16];

  // Model: mode 0=idle 1=run 2=hold; rc counts running cycles, pos counts steps.
  int         m_mode, m_rc, m_pos, m_lr;
  logic [3:0] m_buf [16];
  logic       m_wrap;

  function automatic int period();
    return (m_lr > 6) ? m_lr : 6;
  endfunction

  function automatic int cur_off();
    int p = period();
    return ((m_pos % p) + p) % p;
  endfunction

  function automatic logic [6:0] exp_digit(int k);
    int p, i;
    if (m_mode == 0) return S_BLANK;
    p = period();
    i = (((5 - k - cur_off()) % p) + p) % p;
    return (i < m_lr) ? seg_tab[m_buf[i]] : S_BLANK;
  endfunction

  function automatic logic [6:0] hex_of(int k);
    case (k)
      0: return HEX0;
      1: return HEX1;
      2: return HEX2;
      3: return HEX3;
      4: return HEX4;
      default: return HEX5;
    endcase
  endfunction

  task automatic chk(string tag, logic [6:0] got, logic [6:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rc = 0; m_pos = 0; m_lr = 0; m_wrap = 1'b0;
    for (int i = 0; i < 16; i++) m_buf[i] = 4'hF;
  endtask

  // One clock: predict display from pre-edge model, advance model, check.
  task automatic cyc();
    logic [6:0] e [6];
    logic s_wr, s_start, s_stop, s_pause, s_dir;
    logic [3:0] s_a, s_d;
    logic [4:0] s_len;
    int p, o;
    for (int k = 0; k < 6; k++) e[k] = exp_digit(k);
    s_wr = wr_en; s_a = wr_addr; s_d = wr_data; s_len = len;
    s_start = start; s_stop = stop; s_pause = pause; s_dir = dir;
    @(posedge CLOCK_50);
    if (s_wr) m_buf[s_a] = s_d;
    m_wrap = 1'b0;
    if (m_mode == 0) begin
      if (s_start && !s_stop && s_len != 0) begin
        m_mode = 1; m_lr = (s_len > 16) ? 16 : int'(s_len); m_rc = 0; m_pos = 0;
      end
    end else if (s_stop) begin
      m_mode = 0; m_rc = 0; m_pos = 0;
    end else if (s_pause) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end else if (m_mode == 1) begin
      m_rc++;
      if (m_rc % DIV == 0) begin
        m_pos += s_dir ? -1 : 1;
        p = period();
        o = cur_off();
        m_wrap = s_dir ? (o == p - 1) : (o == 0);
      end
    end
    #1;
    for (int k = 0; k < 6; k++) chk($sformatf("HEX%0d", k), hex_of(k), e[k]);
    chk("busy", {6'b0, busy}, {6'b0, m_mode != 0});
    chk("wrap", {6'b0, wrap}, {6'b0, m_wrap});
    wr_en = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    model_reset();
    for (int k = 0; k < 6; k++) chk($sformatf("rst_HEX%0d", k), hex_of(k), S_BLANK);
    chk("rst_busy", {6'b0, busy}, 7'd0);
    chk("rst_wrap", {6'b0, wrap}, 7'd0);
    @(posedge CLOCK_50);
    #1 RST = 1'b0;
  endtask

  task automatic wr(int a, int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = 4'(d);
    cyc();
  endtask

  task automatic go(int l);
    start = 1'b1; len = 5'(l);
    cyc();
  endtask

  initial begin
    logic [6:0] snap5, snap4;
    int wcnt;
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b1001000, 7'b1111001,
                7'b1110001, 7'b0110000, 7'b1111110, 7'b1111111};
    model_reset();
    do_reset();

    // HI with len=2: period 6
    wr(0, 4'hA); wr(1, 4'hB);
    go(2);
    cyc();
    chk("hi_HEX5", HEX5, S_H); chk("hi_HEX4", HEX4, S_I); chk("hi_HEX3", HEX3, S_BLANK);
    repeat (4) cyc();
    chk("step1_HEX4", HEX4, S_H); chk("step1_HEX3", HEX3, S_I);
    repeat (16) cyc();
    chk("step5_HEX0", HEX0, S_H); chk("step5_HEX5", HEX5, S_I);
    repeat (3) cyc();
    chk("step6_wrap", {6'b0, wrap}, 7'd1);
    cyc();
    chk("back_HEX5", HEX5, S_H); chk("back_HEX4", HEX4, S_I);

    // Mid-run reset
    do_reset();

    // len=8 digits 0..7: wrap every 32 cycles
    for (int i = 0; i < 8; i++) wr(i, i);
    go(8);
    wcnt = 0;
    for (int c = 1; c <= 70; c++) begin
      cyc();
      if (wrap) wcnt++;
      if (c == 9) begin
        chk("off2_HEX5", HEX5, seg_tab[6]);
        chk("off2_HEX4", HEX4, seg_tab[7]);
        chk("off2_HEX3", HEX3, seg_tab[0]);
      end
    end
    chk("wrap_count", 7'(wcnt), 7'd2);

    // Pause/hold/resume
    stop = 1'b1; cyc();
    go(2);
    repeat (8) cyc();
    pause = 1'b1; cyc();
    snap5 = HEX5; snap4 = HEX4;
    chk("hold_off2", HEX3, seg_tab[0]);
    for (int c = 0; c < 20; c++) begin
      cyc();
      chk("hold_HEX5", HEX5, snap5);
      chk("hold_HEX4", HEX4, snap4);
    end
    pause = 1'b1; cyc();
    repeat (4) cyc();
    chk("resume_pre", HEX3, seg_tab[0]);
    cyc();
    chk("resume_step", HEX2, seg_tab[0]);

    // stop+pause together, then start with len=0
    stop = 1'b1; pause = 1'b1; cyc();
    cyc();
    chk("stop_busy", {6'b0, busy}, 7'd0); chk("stop_HEX5", HEX5, S_BLANK);
    go(0);
    cyc();
    chk("len0_busy", {6'b0, busy}, 7'd0);

`ifdef HEX_SCROLL_DIR_EN
    wr(0, 4'hA); wr(1, 4'hB);
    dir = 1'b1;
    go(2);
    repeat (4) cyc();
    chk("dir_wrap", {6'b0, wrap}, 7'd1);
    cyc();
    chk("dir_HEX5", HEX5, S_I); chk("dir_HEX0", HEX0, S_H);
    stop = 1'b1; cyc();
    dir = 1'b0;
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      wr_en   = ($urandom_range(0, 9) < 3);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 4'($urandom_range(0, 15));
      start   = ($urandom_range(0, 19) == 0);
      len     = 5'($urandom_range(0, 20));
      stop    = ($urandom_range(0, 59) == 0);
      pause   = ($urandom_range(0, 29) == 0);
`ifdef HEX_SCROLL_DIR_EN
      dir     = ($urandom_range(0, 3) == 0);
`endif
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
